// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer with prescaler, auto-reload, count latch and
// a level interrupt, sitting on a handshake-free single-word CPU bus.
module mmio_timer #(
    parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ce,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    input  logic        i_we,
    output logic [15:0] o_rdata,
    output logic        o_sel,
    output logic        o_int
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned OFF_W  = 3;

    localparam logic [OFF_W-1:0] OFF_CTRL   = 3'd0;
    localparam logic [OFF_W-1:0] OFF_PRESC  = 3'd1;
    localparam logic [OFF_W-1:0] OFF_RELOAD = 3'd2;
    localparam logic [OFF_W-1:0] OFF_COUNT  = 3'd3;
    localparam logic [OFF_W-1:0] OFF_STATUS = 3'd4;
    localparam logic [OFF_W-1:0] OFF_LATCH  = 3'd5;

    logic              en_q,     en_d;
    logic              auto_q,   auto_d;
    logic              irq_en_q, irq_en_d;
    logic              pend_q,   pend_d;
    logic [DATA_W-1:0] presc_q,  presc_d;
    logic [DATA_W-1:0] reload_q, reload_d;
    logic [DATA_W-1:0] count_q,  count_d;
    logic [DATA_W-1:0] latch_q,  latch_d;
    logic [DATA_W-1:0] pc_q,     pc_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic              int_q,    int_d;

    logic             sel;
    logic [OFF_W-1:0] off;
    logic             wr_ctrl, wr_presc, wr_reload, wr_count, wr_status, wr_latch;
    logic             ctrl_stop, tick, tick_eff, expire;
    logic [DATA_W-1:0] rd_mux;

    assign sel   = (i_addr[15:3] == BASE_ADDR[15:3]);
    assign off   = i_addr[2:0];
    assign o_sel = sel;

    // Next-state: counting first, then bus writes override where they collide
    always_comb begin
        wr_ctrl   = 1'b0;
        wr_presc  = 1'b0;
        wr_reload = 1'b0;
        wr_count  = 1'b0;
        wr_status = 1'b0;
        wr_latch  = 1'b0;
        if (i_we && sel) begin
            case (off)
                OFF_CTRL:   wr_ctrl   = 1'b1;
                OFF_PRESC:  wr_presc  = 1'b1;
                OFF_RELOAD: wr_reload = 1'b1;
                OFF_COUNT:  wr_count  = 1'b1;
                OFF_STATUS: wr_status = 1'b1;
                OFF_LATCH:  wr_latch  = 1'b1;
                default:    ;
            endcase
        end

        // A COUNT write or a disabling CTRL write swallows this cycle's tick
        ctrl_stop = wr_ctrl & ~i_wdata[0];
        tick      = en_q & (pc_q == presc_q);
        tick_eff  = tick & ~wr_count & ~ctrl_stop;
        expire    = tick_eff & (count_q == '0);

        en_d     = en_q;
        auto_d   = auto_q;
        irq_en_d = irq_en_q;
        if (wr_ctrl) begin
            en_d     = i_wdata[0];
            auto_d   = i_wdata[1];
            irq_en_d = i_wdata[2];
        end else if (expire && !auto_q) begin
            en_d = 1'b0;
        end

        presc_d  = wr_presc  ? i_wdata : presc_q;
        reload_d = wr_reload ? i_wdata : reload_q;
        latch_d  = wr_latch  ? count_q : latch_q;

        count_d = count_q;
        if (wr_count) begin
            count_d = i_wdata;
        end else if (tick_eff) begin
            if (count_q != '0) begin
                count_d = count_q - DATA_W'(1);
            end else if (auto_q) begin
                count_d = reload_q;
            end
        end

        if (wr_count || ctrl_stop || !en_q || tick) begin
            pc_d = '0;
        end else begin
            pc_d = pc_q + DATA_W'(1);
        end

        pend_d = expire | (pend_q & ~(wr_status & i_wdata[0]));
        int_d  = pend_q & irq_en_q;

        case (off)
            OFF_CTRL:   rd_mux = {13'd0, irq_en_q, auto_q, en_q};
            OFF_PRESC:  rd_mux = presc_q;
            OFF_RELOAD: rd_mux = reload_q;
            OFF_COUNT:  rd_mux = count_q;
            OFF_STATUS: rd_mux = {15'd0, pend_q};
            OFF_LATCH:  rd_mux = latch_q;
            default:    rd_mux = '0;
        endcase
        rdata_d = sel ? rd_mux : '0;
    end

    // State register; reset is honoured even on edges without clock enable
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            en_q     <= 1'b0;
            auto_q   <= 1'b0;
            irq_en_q <= 1'b0;
            pend_q   <= 1'b0;
            presc_q  <= '0;
            reload_q <= '0;
            count_q  <= '0;
            latch_q  <= '0;
            pc_q     <= '0;
            rdata_q  <= '0;
            int_q    <= 1'b0;
        end else if (i_ce) begin
            en_q     <= en_d;
            auto_q   <= auto_d;
            irq_en_q <= irq_en_d;
            pend_q   <= pend_d;
            presc_q  <= presc_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            latch_q  <= latch_d;
            pc_q     <= pc_d;
            rdata_q  <= rdata_d;
            int_q    <= int_d;
        end
    end

    assign o_rdata = rdata_q;
    assign o_int   = int_q;

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped countdown timer and interrupt source on the CPU data bus. It responds to the CPU's single-word load/store accesses, which have no handshake. It raises the level interrupt that the CPU samples on its `i_int` input. The system bus mux selects `o_rdata` whenever `o_sel` is high.

## Interface
- `BASE_ADDR`, default 16'hFF00: word address of register 0. The block decodes 8 words, BASE_ADDR..BASE_ADDR+7. BASE_ADDR[2:0] must be 0.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, synchronous, active-low.
- `i_ce`  in  1  clock enable. All state, including bus writes, advances only on edges where `i_ce`=1.
- `i_addr`  in  16  bus word address, held by the CPU for ≥2 `i_ce` cycles per access.
- `i_wdata`  in  16  store data.
- `i_we`  in  1  store strobe, one `i_ce` cycle per store.
- `o_rdata`  out  16  registered read data.
- `o_sel`  out  1  combinational; 1 when `i_addr[15:3]`==`BASE_ADDR[15:3]`.
- `o_int`  out  1  interrupt request, registered level.

## Operation
Register map (offset = `i_addr[2:0]`):
- 0 CTRL: bit0 EN, bit1 AUTO (auto-reload), bit2 IRQ_EN. Bits 15:3 read 0.
- 1 PRESC: 16-bit divisor P. A tick occurs every P+1 enabled cycles.
- 2 RELOAD: 16-bit reload value.
- 3 COUNT: current count. A write loads COUNT and clears the prescaler counter.
- 4 STATUS: bit0 PEND. Writing 1 to bit0 clears PEND (W1C); writing 0 has no effect.
- 5 LATCH: any write copies COUNT into LATCH. A read returns LATCH.
- 6, 7: read 0; writes are ignored.

Counting, evaluated on each `i_ce` edge while EN=1:
- Internal 16-bit prescaler counter `pc_cnt`: if `pc_cnt`==P, then tick and set `pc_cnt`<=0; otherwise `pc_cnt`<=`pc_cnt`+1.
- On a tick with COUNT≠0: COUNT<=COUNT-1.
- On a tick with COUNT==0 (expiry): PEND<=1. If AUTO=1, COUNT<=RELOAD. If AUTO=0, EN<=0 and COUNT stays 0.
- While EN=0: `pc_cnt` holds at 0 and COUNT holds.

Interrupt:
- `o_int` <= PEND & IRQ_EN on every `i_ce` edge.
- `o_int` stays high until software clears PEND or IRQ_EN, because the CPU re-arms on IRET.

Collisions within one `i_ce` edge:
- A COUNT write and a tick: the write wins, the tick is discarded, and `pc_cnt`<=0.
- A CTRL write with EN=0 and a tick: the write wins and no decrement occurs.
- A CTRL write with EN=1 while the counter is running: the tick in that cycle proceeds using the old COUNT.
- A STATUS W1C and an expiry: the set wins, so PEND=1.
- An expiry with AUTO=0 and a CTRL write in the same cycle: the written EN value wins.
- A LATCH write and a tick: LATCH takes the pre-edge COUNT.

Accesses outside the decoded window do not change any state.

## Timing
- Reset (`i_rst`=0 at an edge, regardless of `i_ce`): all registers, `pc_cnt`, `o_rdata` and `o_int` go to 0. A reset mid-count discards the count in progress.
- Reads have no side effects. On each `i_ce` edge:
  - `o_rdata` <= the selected register if `o_sel`=1, otherwise 0.
  - The value is valid 1 `i_ce` cycle after the address is stable, which is inside the CPU's 2-cycle address hold.
  - A read of COUNT returns its pre-edge value.
- Writes take effect at the edge where `i_we`=1 and `i_ce`=1, and are visible on the next read.
- Tick rate: with P=0, one tick per `i_ce` cycle.
- Expiry timing: COUNT=N written with EN=1 expires on the (N+1)-th tick, (N+1)(P+1) enabled cycles after enabling.
- PEND rises at the expiry edge. `o_int` rises one `i_ce` edge later.
- Clearing PEND drops `o_int` one `i_ce` edge after the W1C write.

## Test plan
- Reset:
  - Stimulus: drive `i_rst`=0 for 2 cycles, release, then read offsets 0–5.
  - Required response: all reads return 0, `o_int`=0, `o_sel`=1 for 16'hFF00–16'hFF07 and 0 for 16'hFEFF and 16'hFF08.
- Periodic mode:
  - Stimulus: PRESC=0, RELOAD=3, COUNT=3, CTRL=7.
  - Required response: PEND sets on the 4th tick, `o_int` goes to 1 on the next edge, COUNT reads 3 again, and expiry repeats every 4 cycles.
- One-shot with prescaler:
  - Stimulus: PRESC=2, COUNT=1, CTRL=1.
  - Required response: expiry after 6 enabled cycles; CTRL reads 0, COUNT reads 0, STATUS reads 1, and `o_int` stays 0 because IRQ_EN=0.
- W1C collision:
  - Stimulus: write STATUS=1 on the exact expiry edge, then write STATUS=1 again 2 cycles later.
  - Required response: PEND stays 1 after the first write; after the second write PEND reads 0 and `o_int` falls one edge later.
- Clock-enable gating:
  - Stimulus: running count at COUNT=100; hold `i_ce`=0 for 10 cycles with `i_we`=1 to COUNT and `i_wdata`=5.
  - Required response: COUNT still reads 100 afterwards; the write is ignored.
- Decode and LATCH:
  - Stimulus: write 16'hBEEF to offset 6; access 16'hFEFF; write LATCH while COUNT=42 and the counter is running.
  - Required response: offset 6 reads 0; the 16'hFEFF access gives `o_sel`=0 and `o_rdata`=0; LATCH reads 42 while COUNT continues decrementing.
